// File: rtl/triangle_scheduler_if.sv
// Stage bus between the triangle scheduler and its fetch, vertex and pixel stages.
// The scheduler drives start pulses and fetch addresses; the stages answer with eoc pulses.
interface triangle_scheduler_if #(
  parameter int MADDR_WIDTH = 32
);
  logic                   fetch_start;
  logic                   ver_start;
  logic                   pix_start;
  logic                   fetch_eoc;
  logic                   ver_eoc;
  logic                   pix_eoc;
  logic [MADDR_WIDTH-1:0] fetch_addr_vertex;
  logic [MADDR_WIDTH-1:0] fetch_addr_color;

  modport master (
    output fetch_start, ver_start, pix_start, fetch_addr_vertex, fetch_addr_color,
    input  fetch_eoc, ver_eoc, pix_eoc
  );

  modport slave (
    input  fetch_start, ver_start, pix_start, fetch_addr_vertex, fetch_addr_color,
    output fetch_eoc, ver_eoc, pix_eoc
  );
endinterface

// File: rtl/triangle_scheduler.sv
// Three-stage (fetch / vertex / pixel) triangle pipeline scheduler for one frame at a time.
// Optional GPU_SCHED_PERF_EN adds a saturating frame_cycles counter output.
module triangle_scheduler #(
  parameter int MADDR_WIDTH   = 32,
  parameter int VERTEX_STRIDE = 6,
  parameter int COLOR_STRIDE  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [31:0]            triangles_count,
  input  logic [MADDR_WIDTH-1:0] base_addr_vertex,
  input  logic [MADDR_WIDTH-1:0] base_addr_color,
  triangle_scheduler_if.master   stage,
  output logic                   busy,
  output logic                   frame_end,
  output logic [31:0]            cur_triangle
`ifdef GPU_SCHED_PERF_EN
  ,output logic [31:0]           frame_cycles
`endif
);

  localparam logic [MADDR_WIDTH-1:0] VTX_STEP = MADDR_WIDTH'(VERTEX_STRIDE);
  localparam logic [MADDR_WIDTH-1:0] COL_STEP = MADDR_WIDTH'(COLOR_STRIDE);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            idx_q, idx_d;
  logic [31:0]            cur_tri_q, cur_tri_d;
  logic [MADDR_WIDTH-1:0] nxt_vtx_q, nxt_vtx_d;
  logic [MADDR_WIDTH-1:0] nxt_col_q, nxt_col_d;
  logic [MADDR_WIDTH-1:0] cur_vtx_q, cur_vtx_d;
  logic [MADDR_WIDTH-1:0] cur_col_q, cur_col_d;
  logic                   vf_q, vf_d, vv_q, vv_d, vp_q, vp_d;
  logic                   df_q, df_d, dv_q, dv_d, dp_q, dp_d;
`ifdef GPU_SCHED_PERF_EN
  logic [31:0]            cyc_q, cyc_d;
`endif

  logic adv;
  logic issue;
  logic drained;

  // Advance fires when every occupied stage has reported done; an empty pipe always advances.
  assign adv     = (state_q == RUN) && (!vf_q || df_q) && (!vv_q || dv_q) && (!vp_q || dp_q);
  assign issue   = adv && (idx_q < count_q);
  assign drained = adv && (idx_q == count_q) && !vf_q && !vv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      cur_tri_q <= '0;
      nxt_vtx_q <= '0;
      nxt_col_q <= '0;
      cur_vtx_q <= '0;
      cur_col_q <= '0;
      vf_q      <= 1'b0;
      vv_q      <= 1'b0;
      vp_q      <= 1'b0;
      df_q      <= 1'b0;
      dv_q      <= 1'b0;
      dp_q      <= 1'b0;
`ifdef GPU_SCHED_PERF_EN
      cyc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      cur_tri_q <= cur_tri_d;
      nxt_vtx_q <= nxt_vtx_d;
      nxt_col_q <= nxt_col_d;
      cur_vtx_q <= cur_vtx_d;
      cur_col_q <= cur_col_d;
      vf_q      <= vf_d;
      vv_q      <= vv_d;
      vp_q      <= vp_d;
      df_q      <= df_d;
      dv_q      <= dv_d;
      dp_q      <= dp_d;
`ifdef GPU_SCHED_PERF_EN
      cyc_q     <= cyc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    cur_tri_d = cur_tri_q;
    nxt_vtx_d = nxt_vtx_q;
    nxt_col_d = nxt_col_q;
    cur_vtx_d = cur_vtx_q;
    cur_col_d = cur_col_q;
    vf_d      = vf_q;
    vv_d      = vv_q;
    vp_d      = vp_q;
    df_d      = df_q | (vf_q & stage.fetch_eoc);
    dv_d      = dv_q | (vv_q & stage.ver_eoc);
    dp_d      = dp_q | (vp_q & stage.pix_eoc);
`ifdef GPU_SCHED_PERF_EN
    cyc_d     = cyc_q;
`endif

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = RUN;
          count_d   = triangles_count;
          idx_d     = '0;
          nxt_vtx_d = base_addr_vertex;
          nxt_col_d = base_addr_color;
`ifdef GPU_SCHED_PERF_EN
          cyc_d     = '0;
`endif
        end
      end
      RUN: begin
        if (drained) state_d = IDLE;
`ifdef GPU_SCHED_PERF_EN
        if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
`endif
      end
      default: state_d = IDLE;
    endcase

    // On advance, an eoc seen in the same cycle belongs to the stage's new occupant.
    if (adv) begin
      vp_d = vv_q;
      vv_d = vf_q;
      vf_d = issue;
      df_d = vf_d & stage.fetch_eoc;
      dv_d = vv_d & stage.ver_eoc;
      dp_d = vp_d & stage.pix_eoc;
    end

    if (issue) begin
      idx_d     = idx_q + 32'd1;
      cur_tri_d = idx_q;
      cur_vtx_d = nxt_vtx_q;
      cur_col_d = nxt_col_q;
      nxt_vtx_d = nxt_vtx_q + VTX_STEP;
      nxt_col_d = nxt_col_q + COL_STEP;
    end
  end

  // During the issue cycle the new addresses show directly; otherwise the last issued ones hold.
  always_comb begin
    stage.fetch_start       = issue;
    stage.ver_start         = adv & vf_q;
    stage.pix_start         = adv & vv_q;
    stage.fetch_addr_vertex = issue ? nxt_vtx_q : cur_vtx_q;
    stage.fetch_addr_color  = issue ? nxt_col_q : cur_col_q;
    cur_triangle            = issue ? idx_q : cur_tri_q;
    busy                    = (state_q == RUN);
    frame_end               = drained;
`ifdef GPU_SCHED_PERF_EN
    frame_cycles            = cyc_q;
`endif
  end

endmodule

// File: tb/tb_triangle_scheduler.sv
// Self-checking bench for triangle_scheduler: stage latency models, fetch-address scoreboard
// and per-scenario cycle-offset signatures.
module tb_triangle_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [31:0] triangles_count;
  logic [31:0] base_addr_vertex;
  logic [31:0] base_addr_color;
  logic        busy;
  logic        frame_end;
  logic [31:0] cur_triangle;
`ifdef GPU_SCHED_PERF_EN
  logic [31:0] frame_cycles;
`endif

  triangle_scheduler_if #(.MADDR_WIDTH(32)) sif ();

  triangle_scheduler #(
    .MADDR_WIDTH   (32),
    .VERTEX_STRIDE (6),
    .COLOR_STRIDE  (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_start      (frame_start),
    .triangles_count  (triangles_count),
    .base_addr_vertex (base_addr_vertex),
    .base_addr_color  (base_addr_color),
    .stage            (sif),
    .busy             (busy),
    .frame_end        (frame_end),
    .cur_triangle     (cur_triangle)
`ifdef GPU_SCHED_PERF_EN
   ,.frame_cycles     (frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] c;
    logic [31:0] i;
  } exp_t;

  exp_t exp_q[$];
  exp_t ent;

  int checks = 0;
  int failures = 0;

  int    cyc = 0, cyc0 = 0;
  int    lat_f = 1, lat_v = 1, lat_p = 1;
  int    cnt_f = 0, cnt_v = 0, cnt_p = 0;
  logic  f_eoc = 1'b0, v_eoc = 1'b0, p_eoc = 1'b0, p_spur = 1'b0;
  int    frame_n = 0, fetch_cnt = 0, busy_cyc = 0, pix_eoc_cnt = 0, pix_at_fe = 0, fe_total = 0;
  bit    overlap_seen = 1'b0;
  string fetch_sig = "", ver_sig = "", pix_sig = "", fe_sig = "";
  logic [31:0] last_v = '0, last_c = '0;

  assign sif.fetch_eoc = f_eoc;
  assign sif.ver_eoc   = v_eoc;
  assign sif.pix_eoc   = p_eoc | p_spur;

  // Mid-cycle monitor: logs start/end offsets, scores fetch addresses, then models stage latencies.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sif.fetch_start) begin
      fetch_sig = {fetch_sig, $sformatf("%0d ", cyc - cyc0)};
      fetch_cnt = fetch_cnt + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("[TB] FAIL unexpected_fetch: got addr %h, required no fetch", sif.fetch_addr_vertex);
      end else begin
        ent = exp_q.pop_front();
        if (sif.fetch_addr_vertex !== ent.v || sif.fetch_addr_color !== ent.c || cur_triangle !== ent.i) begin
          failures = failures + 1;
          $display("[TB] FAIL fetch_addr: got v=%h c=%h tri=%0d, required v=%h c=%h tri=%0d",
                   sif.fetch_addr_vertex, sif.fetch_addr_color, cur_triangle, ent.v, ent.c, ent.i);
        end
      end
      last_v = sif.fetch_addr_vertex;
      last_c = sif.fetch_addr_color;
    end else if (busy && fetch_cnt > 0 && fetch_cnt < frame_n) begin
      checks = checks + 1;
      if (sif.fetch_addr_vertex !== last_v || sif.fetch_addr_color !== last_c) begin
        failures = failures + 1;
        $display("[TB] FAIL addr_hold: got v=%h c=%h, required v=%h c=%h",
                 sif.fetch_addr_vertex, sif.fetch_addr_color, last_v, last_c);
      end
    end
    if (sif.ver_start) ver_sig = {ver_sig, $sformatf("%0d ", cyc - cyc0)};
    if (sif.pix_start) pix_sig = {pix_sig, $sformatf("%0d ", cyc - cyc0)};
    if (int'(sif.fetch_start) + int'(sif.ver_start) + int'(sif.pix_start) >= 2) overlap_seen = 1'b1;
    if (frame_end) begin
      fe_sig    = {fe_sig, $sformatf("%0d ", cyc - cyc0)};
      fe_total  = fe_total + 1;
      pix_at_fe = pix_eoc_cnt;
    end
    if (busy) busy_cyc = busy_cyc + 1;

    if (frame_start && !busy && !reset) begin
      cyc0 = cyc;
      fetch_sig = ""; ver_sig = ""; pix_sig = ""; fe_sig = "";
      fetch_cnt = 0; busy_cyc = 0; pix_eoc_cnt = 0; pix_at_fe = 0; overlap_seen = 1'b0;
      frame_n = int'(triangles_count);
      exp_q.delete();
      for (int k = 0; k < frame_n; k++) begin
        ent.v = base_addr_vertex + 32'(k * 6);
        ent.c = base_addr_color + 32'(k * 16);
        ent.i = 32'(k);
        exp_q.push_back(ent);
      end
    end

    f_eoc = 1'b0; v_eoc = 1'b0; p_eoc = 1'b0;
    if (cnt_f != 0) begin cnt_f = cnt_f - 1; if (cnt_f == 0) f_eoc = 1'b1; end
    if (cnt_v != 0) begin cnt_v = cnt_v - 1; if (cnt_v == 0) v_eoc = 1'b1; end
    if (cnt_p != 0) begin cnt_p = cnt_p - 1; if (cnt_p == 0) p_eoc = 1'b1; end
    if (sif.fetch_start) begin if (lat_f == 0) f_eoc = 1'b1; else cnt_f = lat_f; end
    if (sif.ver_start)   begin if (lat_v == 0) v_eoc = 1'b1; else cnt_v = lat_v; end
    if (sif.pix_start)   begin if (lat_p == 0) p_eoc = 1'b1; else cnt_p = lat_p; end
    if (p_eoc) pix_eoc_cnt = pix_eoc_cnt + 1;

    if (reset) begin
      cnt_f = 0; cnt_v = 0; cnt_p = 0;
      f_eoc = 1'b0; v_eoc = 1'b0; p_eoc = 1'b0;
      exp_q.delete();
      frame_n = 0;
    end
  end

  task automatic start_frame(input int n, input logic [31:0] bv, input logic [31:0] bc);
    @(posedge clk); #1;
    triangles_count  = 32'(n);
    base_addr_vertex = bv;
    base_addr_color  = bc;
    frame_start      = 1'b1;
    @(posedge clk); #1;
    frame_start      = 1'b0;
  endtask

  task automatic wait_fe(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (fe_sig != "") begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks = checks + 3;
    if ({sif.fetch_start, sif.ver_start, sif.pix_start} !== 3'b000) begin
      failures = failures + 1;
      $display("[TB] FAIL reset_starts: got %b, required 000", {sif.fetch_start, sif.ver_start, sif.pix_start});
    end
    if (sif.fetch_addr_vertex !== 32'd0 || sif.fetch_addr_color !== 32'd0 || cur_triangle !== 32'd0) begin
      failures = failures + 1;
      $display("[TB] FAIL reset_addrs: got v=%h c=%h tri=%h, required all 0",
               sif.fetch_addr_vertex, sif.fetch_addr_color, cur_triangle);
    end
    if ({busy, frame_end} !== 2'b00) begin
      failures = failures + 1;
      $display("[TB] FAIL reset_status: got busy/frame_end %b, required 00", {busy, frame_end});
    end
`ifdef GPU_SCHED_PERF_EN
    checks = checks + 1;
    if (frame_cycles !== 32'd0) begin
      failures = failures + 1;
      $display("[TB] FAIL reset_frame_cycles: got %0d, required 0", frame_cycles);
    end
`endif
  endtask

  task automatic test_single;
    bit ok;
    lat_f = 1; lat_v = 1; lat_p = 1;
    start_frame(1, 32'h100, 32'h200);
    wait_fe(100, ok);
    checks = checks + 6;
    if (!ok) begin failures = failures + 1; $display("[TB] FAIL single_timeout: got no frame_end, required one"); end
    if (fetch_sig != "1 ") begin failures = failures + 1; $display("[TB] FAIL single_fetch: got '%s', required '1 '", fetch_sig); end
    if (ver_sig != "3 ") begin failures = failures + 1; $display("[TB] FAIL single_ver: got '%s', required '3 '", ver_sig); end
    if (pix_sig != "5 ") begin failures = failures + 1; $display("[TB] FAIL single_pix: got '%s', required '5 '", pix_sig); end
    if (fe_sig != "7 ") begin failures = failures + 1; $display("[TB] FAIL single_fe: got '%s', required '7 '", fe_sig); end
    if (busy_cyc != 7 || busy !== 1'b0) begin
      failures = failures + 1;
      $display("[TB] FAIL single_busy: got %0d cycles busy=%b, required 7 cycles busy=0", busy_cyc, busy);
    end
`ifdef GPU_SCHED_PERF_EN
    checks = checks + 2;
    if (frame_cycles !== 32'(busy_cyc)) begin
      failures = failures + 1;
      $display("[TB] FAIL perf_count: got %0d, required %0d", frame_cycles, busy_cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    if (frame_cycles !== 32'd7) begin
      failures = failures + 1;
      $display("[TB] FAIL perf_hold: got %0d, required 7", frame_cycles);
    end
`endif
    repeat (2) @(posedge clk);
  endtask

  task automatic test_staggered(input bit disturb);
    bit ok;
    lat_f = 2; lat_v = 5; lat_p = 1;
    start_frame(3, 32'h100, 32'h200);
    if (disturb) begin
      @(posedge clk); #1; p_spur = 1'b1;
      @(posedge clk); #1; p_spur = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      triangles_count = 32'd7; base_addr_vertex = 32'h5000; base_addr_color = 32'h6000; frame_start = 1'b1;
      @(posedge clk); #1; frame_start = 1'b0;
    end
    wait_fe(200, ok);
    checks = checks + 8;
    if (!ok) begin failures = failures + 1; $display("[TB] FAIL stagger_timeout: got no frame_end, required one"); end
    if (fetch_sig != "1 4 10 ") begin failures = failures + 1; $display("[TB] FAIL stagger_fetch: got '%s', required '1 4 10 '", fetch_sig); end
    if (ver_sig != "4 10 16 ") begin failures = failures + 1; $display("[TB] FAIL stagger_ver: got '%s', required '4 10 16 '", ver_sig); end
    if (pix_sig != "10 16 22 ") begin failures = failures + 1; $display("[TB] FAIL stagger_pix: got '%s', required '10 16 22 '", pix_sig); end
    if (fe_sig != "24 ") begin failures = failures + 1; $display("[TB] FAIL stagger_fe: got '%s', required '24 '", fe_sig); end
    if (pix_at_fe != 3) begin failures = failures + 1; $display("[TB] FAIL stagger_pix_eoc: got %0d before frame_end, required 3", pix_at_fe); end
    if (!overlap_seen) begin failures = failures + 1; $display("[TB] FAIL stagger_overlap: got 0, required 1"); end
    if (exp_q.size() != 0) begin failures = failures + 1; $display("[TB] FAIL stagger_missing_fetch: got %0d left, required 0", exp_q.size()); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_count;
    bit ok;
    lat_f = 1; lat_v = 1; lat_p = 1;
    start_frame(0, 32'h700, 32'h800);
    wait_fe(20, ok);
    checks = checks + 4;
    if (!ok) begin failures = failures + 1; $display("[TB] FAIL zero_timeout: got no frame_end, required one"); end
    if (fe_sig != "1 ") begin failures = failures + 1; $display("[TB] FAIL zero_fe: got '%s', required '1 '", fe_sig); end
    if (fetch_sig != "" || ver_sig != "" || pix_sig != "") begin
      failures = failures + 1;
      $display("[TB] FAIL zero_starts: got f='%s' v='%s' p='%s', required none", fetch_sig, ver_sig, pix_sig);
    end
    if (busy_cyc != 1) begin failures = failures + 1; $display("[TB] FAIL zero_busy: got %0d cycles, required 1", busy_cyc); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int fe_before;
    lat_f = 2; lat_v = 5; lat_p = 1;
    start_frame(3, 32'h100, 32'h200);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (fetch_cnt >= 2) begin ok = 1'b1; break; end
    end
    checks = checks + 1;
    if (!ok) begin failures = failures + 1; $display("[TB] FAIL midreset_timeout: got %0d fetches, required 2", fetch_cnt); end
    fe_before = fe_total;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks = checks + 2;
    if ({sif.fetch_start, sif.ver_start, sif.pix_start, busy, frame_end} !== 5'b0 ||
        sif.fetch_addr_vertex !== 32'd0 || sif.fetch_addr_color !== 32'd0 || cur_triangle !== 32'd0) begin
      failures = failures + 1;
      $display("[TB] FAIL midreset_outputs: got starts=%b busy=%b fe=%b v=%h c=%h tri=%h, required all 0",
               {sif.fetch_start, sif.ver_start, sif.pix_start}, busy, frame_end,
               sif.fetch_addr_vertex, sif.fetch_addr_color, cur_triangle);
    end
    repeat (30) @(posedge clk);
    #1;
    if (fe_total != fe_before) begin
      failures = failures + 1;
      $display("[TB] FAIL midreset_no_fe: got %0d frame_end pulses, required 0", fe_total - fe_before);
    end
    lat_f = 1; lat_v = 1; lat_p = 1;
    start_frame(1, 32'h300, 32'h400);
    wait_fe(100, ok);
    checks = checks + 2;
    if (!ok || fe_sig != "7 ") begin failures = failures + 1; $display("[TB] FAIL midreset_restart_fe: got '%s', required '7 '", fe_sig); end
    if (fetch_sig != "1 " || ver_sig != "3 " || pix_sig != "5 ") begin
      failures = failures + 1;
      $display("[TB] FAIL midreset_restart_starts: got f='%s' v='%s' p='%s', required '1 ' '3 ' '5 '", fetch_sig, ver_sig, pix_sig);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_latency_wrap;
    bit ok;
    lat_f = 0; lat_v = 0; lat_p = 0;
    start_frame(2, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
    wait_fe(50, ok);
    checks = checks + 4;
    if (!ok || fe_sig != "5 ") begin failures = failures + 1; $display("[TB] FAIL zlat_fe: got '%s', required '5 '", fe_sig); end
    if (fetch_sig != "1 2 ") begin failures = failures + 1; $display("[TB] FAIL zlat_fetch: got '%s', required '1 2 '", fetch_sig); end
    if (ver_sig != "2 3 ") begin failures = failures + 1; $display("[TB] FAIL zlat_ver: got '%s', required '2 3 '", ver_sig); end
    if (pix_sig != "3 4 ") begin failures = failures + 1; $display("[TB] FAIL zlat_pix: got '%s', required '3 4 '", pix_sig); end
    lat_f = 1; lat_v = 1; lat_p = 1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    triangles_count = '0;
    base_addr_vertex = '0;
    base_addr_color = '0;
    test_reset();
    test_single();
    test_staggered(1'b0);
    test_staggered(1'b1);
    test_zero_count();
    test_reset_mid_frame();
    test_zero_latency_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
